// File: rtl/key_input_conditioner.sv
// ============================================================================
//  Module      : key_input_conditioner
//  Description : Synchronizes and debounces 13 note keys plus the mode and
//                octave buttons. The highest pressed key is encoded as a note
//                index with a change strobe. Mode and octave presses advance
//                wrapping counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_input_conditioner #(
    parameter int SAMPLE_DIV  = 12000,
    parameter int DB_DEPTH    = 4,
    parameter int NUM_MODES   = 4,
    parameter int NUM_OCTAVES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] pb_keys,
    input  logic        pb_mode,
    input  logic        pb_octave,
    output logic [12:0] keys_db,
    output logic [3:0]  note_idx,
    output logic        note_valid,
    output logic        note_chg,
    output logic [1:0]  mode,
    output logic [1:0]  octave,
    output logic        mode_pulse,
    output logic        octave_pulse
);

    // Input bit map: [12:0] note keys, [13] mode button, [14] octave button.
    localparam int                 c_NUM_IN    = 15;
    localparam int                 c_CNT_W     = $clog2(SAMPLE_DIV);
    localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [1:0]         c_MODE_LAST = 2'(NUM_MODES - 1);
    localparam logic [1:0]         c_OCT_LAST  = 2'(NUM_OCTAVES - 1);

    logic [c_NUM_IN-1:0] w_raw;
    logic [c_NUM_IN-1:0] r_sync1;
    logic [c_NUM_IN-1:0] r_sync2;
    logic [c_CNT_W-1:0]  r_tick_cnt;
    logic                w_tick;
    logic [DB_DEPTH-1:0] r_hist      [c_NUM_IN];
    logic [DB_DEPTH-1:0] w_hist_next [c_NUM_IN];
    logic [c_NUM_IN-1:0] r_db;
    logic [12:0]         r_keys_db;
    logic [3:0]          w_enc_idx;
    logic                w_enc_valid;
    logic [3:0]          r_note_idx;
    logic                r_note_valid;
    logic                r_note_chg;
    logic [1:0]          r_ctl_prev;
    logic                w_mode_press;
    logic                w_oct_press;
    logic [1:0]          r_mode;
    logic [1:0]          r_octave;
    logic                r_mode_pulse;
    logic                r_oct_pulse;

    assign w_raw = {pb_octave, pb_mode, pb_keys};

    // Two-flop synchronizer for every asynchronous button input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running sample divider; the tick marks its last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_CNT_W'(1);
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // Candidate history for each input: newest synced sample in the LSB.
    for (genvar g = 0; g < c_NUM_IN; g++) begin : g_hist
        assign w_hist_next[g] = {r_hist[g][DB_DEPTH-2:0], r_sync2[g]};
    end

    // On each tick, shift in a sample; the level moves only on a unanimous history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '{default: '0};
            r_db   <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < c_NUM_IN; i++) begin
                r_hist[i] <= w_hist_next[i];
                if (&w_hist_next[i]) begin
                    r_db[i] <= 1'b1;
                end else if (~|w_hist_next[i]) begin
                    r_db[i] <= 1'b0;
                end
            end
        end
    end

    // Highest set key wins; an empty key set encodes as index 0, invalid.
    always_comb begin
        w_enc_idx   = '0;
        w_enc_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (r_keys_db[i]) begin
                w_enc_idx   = 4'(i);
                w_enc_valid = 1'b1;
            end
        end
    end

    // Key path registers: debounced levels, then encoded note with change strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys_db    <= '0;
            r_note_idx   <= '0;
            r_note_valid <= 1'b0;
            r_note_chg   <= 1'b0;
        end else begin
            r_keys_db    <= r_db[12:0];
            r_note_idx   <= w_enc_idx;
            r_note_valid <= w_enc_valid;
            r_note_chg   <= ({w_enc_valid, w_enc_idx} != {r_note_valid, r_note_idx});
        end
    end

    // A press is accepted on the debounced 0->1 transition only.
    assign w_mode_press = r_db[13] & ~r_ctl_prev[0];
    assign w_oct_press  = r_db[14] & ~r_ctl_prev[1];

    // Control path: edge history and wrapping mode/octave counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl_prev   <= '0;
            r_mode       <= '0;
            r_octave     <= '0;
            r_mode_pulse <= 1'b0;
            r_oct_pulse  <= 1'b0;
        end else begin
            r_ctl_prev   <= r_db[14:13];
            r_mode_pulse <= w_mode_press;
            r_oct_pulse  <= w_oct_press;
            if (w_mode_press) begin
                r_mode <= (r_mode == c_MODE_LAST) ? 2'd0 : r_mode + 2'd1;
            end
            if (w_oct_press) begin
                r_octave <= (r_octave == c_OCT_LAST) ? 2'd0 : r_octave + 2'd1;
            end
        end
    end

    assign keys_db      = r_keys_db;
    assign note_idx     = r_note_idx;
    assign note_valid   = r_note_valid;
    assign note_chg     = r_note_chg;
    assign mode         = r_mode;
    assign octave       = r_octave;
    assign mode_pulse   = r_mode_pulse;
    assign octave_pulse = r_oct_pulse;

endmodule

`default_nettype wire

// File: tb/tb_key_input_conditioner.sv
// ============================================================================
//  Module      : tb_key_input_conditioner
//  Description : Directed self-checking bench for key_input_conditioner with
//                SAMPLE_DIV=4, DB_DEPTH=4. A second instance with
//                NUM_OCTAVES=3 shares the stimulus to cover octave wrap at 3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_input_conditioner;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] pb_keys;
    logic        pb_mode;
    logic        pb_octave;

    logic [12:0] keys_db;
    logic [3:0]  note_idx;
    logic        note_valid, note_chg;
    logic [1:0]  mode, octave;
    logic        mode_pulse, octave_pulse;

    logic [12:0] d3_keys_db;
    logic [3:0]  d3_note_idx;
    logic        d3_note_valid, d3_note_chg;
    logic [1:0]  d3_mode, d3_octave;
    logic        d3_mode_pulse, d3_octave_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_chg, cnt_mode, cnt_oct, cnt_oct3;

    always #5 clk = ~clk;

    key_input_conditioner #(
        .SAMPLE_DIV(4), .DB_DEPTH(4), .NUM_MODES(4), .NUM_OCTAVES(4)
    ) dut (
        .clk(clk), .reset(reset), .pb_keys(pb_keys), .pb_mode(pb_mode),
        .pb_octave(pb_octave), .keys_db(keys_db), .note_idx(note_idx),
        .note_valid(note_valid), .note_chg(note_chg), .mode(mode),
        .octave(octave), .mode_pulse(mode_pulse), .octave_pulse(octave_pulse)
    );

    key_input_conditioner #(
        .SAMPLE_DIV(4), .DB_DEPTH(4), .NUM_MODES(4), .NUM_OCTAVES(3)
    ) dut3 (
        .clk(clk), .reset(reset), .pb_keys(pb_keys), .pb_mode(pb_mode),
        .pb_octave(pb_octave), .keys_db(d3_keys_db), .note_idx(d3_note_idx),
        .note_valid(d3_note_valid), .note_chg(d3_note_chg), .mode(d3_mode),
        .octave(d3_octave), .mode_pulse(d3_mode_pulse), .octave_pulse(d3_octave_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample and drive 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (note_chg)        cnt_chg++;
        if (mode_pulse)      cnt_mode++;
        if (octave_pulse)    cnt_oct++;
        if (d3_octave_pulse) cnt_oct3++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        cnt_chg = 0; cnt_mode = 0; cnt_oct = 0; cnt_oct3 = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"},
            {keys_db, note_idx, note_valid, note_chg, mode, octave, mode_pulse, octave_pulse},
            '0);
        chk({tag, "_d3oct"}, {30'd0, d3_octave}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [1:0] exp_mode [5];
        logic [1:0] exp_oct  [3];
        logic [1:0] exp_oct3 [3];
        exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_oct  = '{2'd1, 2'd2, 2'd3};
        exp_oct3 = '{2'd1, 2'd2, 2'd0};

        pb_keys = '0; pb_mode = 1'b0; pb_octave = 1'b0; reset = 1'b0;
        clr();
        #1;

        // Reset and idle
        do_reset(3);
        chk_all_zero("reset");
        clr();
        run(200);
        chk("idle_chg",  cnt_chg,  0);
        chk("idle_mode", cnt_mode, 0);
        chk("idle_oct",  cnt_oct,  0);
        chk_all_zero("idle");

        // Single key 5 press and release
        pb_keys[5] = 1'b1;
        clr();
        lat = 0;
        while (keys_db[5] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk("k5_rise_seen", keys_db[5], 1'b1);
        chk("k5_latency_le19", (lat <= 19), 1'b1);
        chk("k5_note_lag", note_valid, 1'b0);
        step();
        chk("k5_idx",   note_idx,   4'd5);
        chk("k5_valid", note_valid, 1'b1);
        chk("k5_chg",   note_chg,   1'b1);
        step();
        chk("k5_chg_1cyc", note_chg, 1'b0);
        clr();
        pb_keys[5] = 1'b0;
        run(40);
        chk("k5_rel_db",    keys_db,    13'd0);
        chk("k5_rel_valid", note_valid, 1'b0);
        chk("k5_rel_idx",   note_idx,   4'd0);
        chk("k5_rel_chg",   cnt_chg,    1);

        // Keys 3 and 11: highest wins, then falls back to 3
        clr();
        pb_keys[3] = 1'b1;
        pb_keys[11] = 1'b1;
        run(40);
        chk("k3_11_idx",   note_idx,   4'd11);
        chk("k3_11_valid", note_valid, 1'b1);
        chk("k3_11_db",    keys_db,    13'h0808);
        pb_keys[11] = 1'b0;
        run(40);
        chk("k3_idx",   note_idx, 4'd3);
        chk("k3_chg2",  cnt_chg,  2);
        pb_keys[3] = 1'b0;
        run(40);
        chk("k3_rel_valid", note_valid, 1'b0);

        // Mode bounce alternating across sample ticks must not register
        clr();
        for (int i = 0; i < 10; i++) begin
            pb_mode = ~pb_mode;
            run(4);
        end
        chk("bounce_nopulse", cnt_mode, 0);
        chk("bounce_mode",    mode,     2'd0);
        pb_mode = 1'b1;
        run(40);
        chk("settle_pulse", cnt_mode, 1);
        chk("settle_mode",  mode,     2'd1);
        run(60);
        chk("hold_noretrig", cnt_mode, 1);
        pb_mode = 1'b0;
        run(40);
        chk("release_nopulse", cnt_mode, 1);

        // Clean presses; first mode and octave presses share a cycle
        do_reset(2);
        chk_all_zero("reset2");
        for (int p = 0; p < 5; p++) begin
            clr();
            pb_mode = 1'b1;
            if (p < 3) pb_octave = 1'b1;
            if (p == 0) begin
                lat = 0;
                while (mode_pulse !== 1'b1 && lat < 40) begin
                    step();
                    lat++;
                end
                chk("shared_mpulse",  mode_pulse,      1'b1);
                chk("shared_opulse",  octave_pulse,    1'b1);
                chk("shared_o3pulse", d3_octave_pulse, 1'b1);
                chk("shared_mode_vis", mode,           2'd1);
            end
            run(30);
            chk($sformatf("press%0d_mode", p), mode, exp_mode[p]);
            chk($sformatf("press%0d_mcnt", p), cnt_mode, 1);
            if (p < 3) begin
                chk($sformatf("press%0d_oct", p),  octave,    exp_oct[p]);
                chk($sformatf("press%0d_oct3", p), d3_octave, exp_oct3[p]);
                chk($sformatf("press%0d_ocnt", p), cnt_oct,   1);
            end
            pb_mode = 1'b0;
            pb_octave = 1'b0;
            run(30);
        end

        // Reset while the octave button is held
        do_reset(2);
        clr();
        pb_octave = 1'b1;
        run(30);
        chk("held_oct_pre", octave, 2'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all_zero("midreset");
        clr();
        run(40);
        chk("held_oct_post", octave,  2'd1);
        chk("held_oct_cnt",  cnt_oct, 1);
        chk("held_mode",     mode,    2'd0);
        pb_octave = 1'b0;
        run(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
